// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: one SW-bit slice per rank, carry registered between ranks; global stall on out_ready.
// Latency STAGES cycles, one result per cycle; optional signed-overflow output Ovf under RCA_PIPE_OVF_EN.
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  // Operands shift right by SW per rank so each slice always works on the low SW bits.
  // The sum shifts right the same way, with each new slice entering at the top.
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cy;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];

  logic [WIDTH-1:0]  w_ain   [STAGES];
  logic [WIDTH-1:0]  w_bin   [STAGES];
  logic [WIDTH-1:0]  w_sprev [STAGES];
  logic [SW-1:0]     w_s     [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_co;
  logic              w_adv;

  assign w_adv     = ~r_vld[L] | out_ready;
  assign in_ready  = w_adv & ~rst;
  assign out_valid = r_vld[L];
  assign Sum       = r_sum[L];
  assign Cout      = r_cy[L];

  always_comb begin : comb_slice
    logic w_c;
    w_ain[0]   = A;
    w_bin[0]   = B;
    w_cin[0]   = Cin;
    w_sprev[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_ain[k]   = r_a[k-1];
      w_bin[k]   = r_b[k-1];
      w_cin[k]   = r_cy[k-1];
      w_sprev[k] = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_c    = w_cin[k];
      w_s[k] = '0;
      for (int j = 0; j < SW; j++) begin
        w_s[k][j] = w_ain[k][j] ^ w_bin[k][j] ^ w_c;
        w_c       = (w_ain[k][j] & w_bin[k][j]) | (w_c & (w_ain[k][j] ^ w_bin[k][j]));
      end
      w_co[k] = w_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= in_valid & in_ready;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_ain[k] >> SW;
        r_b[k]   <= w_bin[k] >> SW;
        r_sum[k] <= (w_sprev[k] >> SW) | (WIDTH'(w_s[k]) << (WIDTH - SW));
        r_cy[k]  <= w_co[k];
      end
    end
  end

`ifdef RCA_PIPE_OVF_EN
  // Carry into the MSB is recovered as a^b^s at that bit.
  logic w_ovf;
  logic r_ovf;
  assign w_ovf = w_ain[L][SW-1] ^ w_bin[L][SW-1] ^ w_s[L][SW-1] ^ w_co[L];
  assign Ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe (WIDTH=16, STAGES=4): reset, carries, streaming, stall, reset flush, overflow.
module tb_rca_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
  logic        out_ready;
`ifdef RCA_PIPE_OVF_EN
  logic        ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  rca_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sum(sum), .Cout(cout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RCA_PIPE_OVF_EN
    , .Ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction through an empty pipe; checks latency and result.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic [15:0] es, input logic ec, input logic eo);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    chk("send_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("send_early_vld", 32'(out_valid), 32'd0);
      step();
    end
    chk("send_vld", 32'(out_valid), 32'd1);
    chk("send_sum", 32'(sum), 32'(es));
    chk("send_cout", 32'(cout), 32'(ec));
`ifdef RCA_PIPE_OVF_EN
    chk("send_ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected X in overflow vector");
`endif
    step();
    chk("send_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; a = 16'h5555; b = 16'h3333; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
`ifdef RCA_PIPE_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0);
`endif

    // Streaming: A=i, B=0x1000*i, expected Sum=0x1001*i
    cin = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        a = 16'(c + 1); b = 16'(16'h1000 * (c + 1)); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (c >= 3 && c < 11) begin
        chk("stream_vld", 32'(out_valid), 32'd1);
        chk("stream_sum", 32'(sum), 32'(16'h1001 * (c - 2)));
      end else begin
        chk("stream_idle", 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: four in flight, stall ten cycles, then drain in order
    out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      a = 16'(16'h1111 * j); b = 16'h0101; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_vld", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h1212);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_sum0", 32'(sum), 32'h1212);
    step();
    chk("drain_sum1", 32'(sum), 32'h2323);
    step();
    chk("drain_sum2", 32'(sum), 32'h3434);
    step();
    chk("drain_sum3", 32'(sum), 32'h4545);
    chk("drain_vld3", 32'(out_valid), 32'd1);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Reset mid-flight: nothing accepted before reset may emerge
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      a = 16'h0042; b = 16'h0001; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("flush_vld", 32'(out_valid), 32'd0);
      step();
    end
    send(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
